fpumul_pipe: RTL and testbench

FPUMUL_PIPE -- requirements
Module: fpumul_pipe

---
 rtl/fpumul_pkg.sv | 36 +++
 rtl/fpumul_round.sv | 35 +++
 rtl/fpumul_pipe.sv | 241 ++++++++++++++++++++++++
 tb/tb_fpumul_pipe.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fpumul_pkg.sv
// Shared types, flag positions and format helpers for the fpumul_pipe multiplier.
package fpumul_pkg;

   typedef enum logic [2:0] {
      RM_TRUNC    = 3'd0,
      RM_ROUND    = 3'd1,
      RM_EVEN     = 3'd2,
      RM_PLUS     = 3'd3,
      RM_MINUS    = 3'd4,
      RM_UP       = 3'd5,
      RM_DOWN     = 3'd6,
      RM_EVEN_ALT = 3'd7
   } rmode_e;

   localparam int FLAG_SPECIAL   = 0;
   localparam int FLAG_INVALID   = 1;
   localparam int FLAG_OVERFLOW  = 2;
   localparam int FLAG_UNDERFLOW = 3;
   localparam int FLAG_INEXACT   = 4;
   localparam int NFLAGS         = 5;

   function automatic int bias(input int expw);
      return (1 << (expw - 1)) - 1;
   endfunction

   // Exponent code for infinity; all-ones is reserved for NaN.
   function automatic int inf_code(input int expw);
      return (1 << expw) - 2;
   endfunction

   // Quiet NaN mantissa: MSB and LSB set.
   function automatic logic [63:0] nan_man(input int manw);
      return (64'd1 << (manw - 1)) | 64'd1;
   endfunction

endpackage

// File: rtl/fpumul_round.sv
// Round-and-carry step: applies the rounding mode to a normalised mantissa.
module fpumul_round
   import fpumul_pkg::*;
#(
   parameter int MANW = 23
) (
   input  logic [MANW-1:0] man,
   input  logic            guard,
   input  logic            sticky,
   input  rmode_e          rmode,
   input  logic            sign,
   output logic [MANW-1:0] man_rnd,
   output logic            carry,
   output logic            inexact
);

   logic inc;

   always_comb begin
      inc = 1'b0;
      case (rmode)
         RM_TRUNC:             inc = 1'b0;
         RM_ROUND:             inc = guard;
         RM_EVEN, RM_EVEN_ALT: inc = guard & (sticky | man[0]);
         // directed modes only move the magnitude when heading away from zero
         RM_PLUS, RM_UP:       inc = ~sign & (guard | sticky);
         RM_MINUS, RM_DOWN:    inc = sign & (guard | sticky);
         default:              inc = 1'b0;
      endcase
   end

   assign {carry, man_rnd} = {1'b0, man} + (MANW + 1)'(inc);
   assign inexact          = guard | sticky;

endmodule

// File: rtl/fpumul_pipe.sv
// Three-stage floating-point multiplier with valid/ready flow control, flush and tag pass-through.
module fpumul_pipe
   import fpumul_pkg::*;
#(
   parameter int EXPW         = 9,
   parameter int MANW         = 23,
   parameter int TAGW         = 6,
   parameter bit CLIP_DEFAULT = 1'b0,
   localparam int W           = EXPW + MANW + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [W-1:0]    A,
   input  logic [W-1:0]    B,
   input  logic            copyA,
   input  logic [2:0]      rmode,
   input  logic            clip_ovr,
   input  logic [TAGW-1:0] tag_in,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [W-1:0]    res,
   output logic [4:0]      flags,
   output logic [TAGW-1:0] tag_out
);

   // Exponent arithmetic carries two extra bits so finite*finite cannot wrap.
   localparam int EW = EXPW + 2;
   localparam int SW = MANW + 1;
   localparam int LO = SW / 2;
   localparam int HI = SW - LO;
   localparam int PW = 2 * SW;

   localparam logic [EXPW-1:0]      E_INF        = EXPW'(inf_code(EXPW));
   localparam logic [EXPW-1:0]      E_MAX        = EXPW'(inf_code(EXPW) - 1);
   localparam logic [EXPW-1:0]      E_NAN        = '1;
   localparam logic signed [EW-1:0] BIAS_S       = EW'(bias(EXPW));
   localparam logic signed [EW-1:0] INF_S        = EW'(inf_code(EXPW));
   localparam logic [63:0]          NAN_MAN_FULL = nan_man(MANW);
   localparam logic [MANW-1:0]      NAN_MAN      = NAN_MAN_FULL[MANW-1:0];

   function automatic logic [EXPW-1:0] exp_of(input logic [W-1:0] x);
      return {x[W-1], x[W-3:MANW]};
   endfunction

   function automatic logic [W-1:0] pack(input logic [EXPW-1:0] e, input logic s,
                                         input logic [MANW-1:0] m);
      return {e[EXPW-1], s, e[EXPW-2:0], m};
   endfunction

   logic stall, accept;
   logic s1_valid, s2_valid, s3_valid;

   assign stall    = s3_valid & ~out_ready;
   assign in_ready = ~stall;
   assign accept   = in_valid & in_ready & ~flush;

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s3_valid <= 1'b0;
      end else if (flush) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s3_valid <= 1'b0;
      end else if (!stall) begin
         s1_valid <= accept;
         s2_valid <= s1_valid;
         s3_valid <= s2_valid;
      end
   end

   // S1: classify, exponent sum, partial products
   logic [EXPW-1:0]      ea, eb;
   logic [SW-1:0]        ma, mb;
   logic                 sign_ab;
   logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic                 special_d;
   logic [W-1:0]         sres_d;
   logic [4:0]           sflags_d;
   logic signed [EW-1:0] exp_sum_d;
   logic [SW+LO-1:0]     pp_lo_d;
   logic [SW+HI-1:0]     pp_hi_d;

   assign ea      = exp_of(A);
   assign eb      = exp_of(B);
   assign ma      = {1'b1, A[MANW-1:0]};
   assign mb      = {1'b1, B[MANW-1:0]};
   assign sign_ab = A[W-2] ^ B[W-2];
   assign a_zero  = (ea == '0);
   assign b_zero  = (eb == '0);
   assign a_inf   = (ea == E_INF);
   assign b_inf   = (eb == E_INF);
   assign a_nan   = (ea == E_NAN);
   assign b_nan   = (eb == E_NAN);

   always_comb begin
      special_d              = 1'b1;
      sres_d                 = '0;
      sflags_d               = '0;
      sflags_d[FLAG_SPECIAL] = 1'b1;
      if (copyA) begin
         sres_d = A;
      end else if (a_nan | b_nan | (a_zero & b_inf) | (a_inf & b_zero)) begin
         sres_d                 = pack(E_NAN, 1'b0, NAN_MAN);
         sflags_d[FLAG_INVALID] = 1'b1;
      end else if (a_zero | b_zero) begin
         sres_d = pack('0, sign_ab, '0);
      end else if (a_inf | b_inf) begin
         sres_d = pack(E_INF, sign_ab, '0);
      end else begin
         special_d = 1'b0;
         sflags_d  = '0;
      end
   end

   assign exp_sum_d = $signed(EW'(ea)) + $signed(EW'(eb)) - BIAS_S;
   assign pp_lo_d   = (SW + LO)'(ma) * (SW + LO)'(mb[LO-1:0]);
   assign pp_hi_d   = (SW + HI)'(ma) * (SW + HI)'(mb[SW-1:LO]);

   logic                 s1_sign, s1_clip, s1_special;
   logic signed [EW-1:0] s1_exp;
   logic [SW+LO-1:0]     s1_pp_lo;
   logic [SW+HI-1:0]     s1_pp_hi;
   rmode_e               s1_rmode;
   logic [TAGW-1:0]      s1_tag;
   logic [W-1:0]         s1_sres;
   logic [4:0]           s1_sflags;

   always_ff @(negedge clk) begin
      if (!stall) begin
         s1_sign    <= sign_ab;
         s1_clip    <= clip_ovr | CLIP_DEFAULT;
         s1_special <= special_d;
         s1_exp     <= exp_sum_d;
         s1_pp_lo   <= pp_lo_d;
         s1_pp_hi   <= pp_hi_d;
         s1_rmode   <= rmode_e'(rmode);
         s1_tag     <= tag_in;
         s1_sres    <= sres_d;
         s1_sflags  <= sflags_d;
      end
   end

   // S2: combine partial products and normalise to [1,2)
   logic [PW-1:0] prod;
   logic [PW-2:0] prod_n;
   logic          norm;

   assign prod   = (PW'(s1_pp_hi) << LO) + PW'(s1_pp_lo);
   assign norm   = prod[PW-1];
   assign prod_n = norm ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};

   logic                 s2_sign, s2_clip, s2_special, s2_guard, s2_sticky;
   logic signed [EW-1:0] s2_exp;
   logic [MANW-1:0]      s2_man;
   rmode_e               s2_rmode;
   logic [TAGW-1:0]      s2_tag;
   logic [W-1:0]         s2_sres;
   logic [4:0]           s2_sflags;

   always_ff @(negedge clk) begin
      if (!stall) begin
         s2_sign    <= s1_sign;
         s2_clip    <= s1_clip;
         s2_special <= s1_special;
         s2_exp     <= s1_exp + EW'(norm);
         s2_man     <= prod_n[PW-2 -: MANW];
         s2_guard   <= prod_n[PW-2-MANW];
         s2_sticky  <= |prod_n[PW-3-MANW:0];
         s2_rmode   <= s1_rmode;
         s2_tag     <= s1_tag;
         s2_sres    <= s1_sres;
         s2_sflags  <= s1_sflags;
      end
   end

   // S3: round, range check, pack
   logic [MANW-1:0]      man_rnd;
   logic                 rnd_carry, rnd_inexact;
   logic signed [EW-1:0] exp_r;
   logic                 ovf, unf;
   logic [W-1:0]         res_d;
   logic [4:0]           flags_d;

   fpumul_round #(.MANW(MANW)) u_round (
      .man     (s2_man),
      .guard   (s2_guard),
      .sticky  (s2_sticky),
      .rmode   (s2_rmode),
      .sign    (s2_sign),
      .man_rnd (man_rnd),
      .carry   (rnd_carry),
      .inexact (rnd_inexact)
   );

   assign exp_r = s2_exp + EW'(rnd_carry);
   assign ovf   = (exp_r >= INF_S);
   assign unf   = exp_r[EW-1] | (exp_r == '0);

   always_comb begin
      res_d   = pack(exp_r[EXPW-1:0], s2_sign, man_rnd);
      flags_d = '0;
      flags_d[FLAG_INEXACT] = rnd_inexact;
      if (s2_special) begin
         res_d   = s2_sres;
         flags_d = s2_sflags;
      end else if (unf) begin
         res_d                   = pack('0, s2_sign, '0);
         flags_d                 = '0;
         flags_d[FLAG_UNDERFLOW] = 1'b1;
         flags_d[FLAG_INEXACT]   = (|s2_man) | s2_guard | s2_sticky;
      end else if (ovf) begin
         res_d                  = s2_clip ? pack(E_MAX, s2_sign, '1) : pack(E_INF, s2_sign, '0);
         flags_d                = '0;
         flags_d[FLAG_OVERFLOW] = 1'b1;
         flags_d[FLAG_INEXACT]  = 1'b1;
      end
   end

   logic [W-1:0]    s3_res;
   logic [4:0]      s3_flags;
   logic [TAGW-1:0] s3_tag;

   always_ff @(negedge clk) begin
      if (!stall) begin
         s3_res   <= res_d;
         s3_flags <= flags_d;
         s3_tag   <= s2_tag;
      end
   end

   assign out_valid = s3_valid;
   assign res       = s3_valid ? s3_res : '0;
   assign flags     = s3_valid ? s3_flags : '0;
   assign tag_out   = s3_valid ? s3_tag : '0;

endmodule

// File: tb/tb_fpumul_pipe.sv
// Directed-vector bench for fpumul_pipe at EXPW=9, MANW=23.
module tb_fpumul_pipe;

   localparam int W    = 33;
   localparam int TAGW = 6;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid, in_ready;
   logic [W-1:0]    op_a, op_b;
   logic            copy_a;
   logic [2:0]      rmode;
   logic            clip_ovr;
   logic [TAGW-1:0] tag_in;
   logic            flush;
   logic            out_valid, out_ready;
   logic [W-1:0]    res;
   logic [4:0]      flags;
   logic [TAGW-1:0] tag_out;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fpumul_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (op_a),
      .B         (op_b),
      .copyA     (copy_a),
      .rmode     (rmode),
      .clip_ovr  (clip_ovr),
      .tag_in    (tag_in),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .res       (res),
      .flags     (flags),
      .tag_out   (tag_out)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic ca,
                        input logic [2:0] rm, input logic cl, input logic [TAGW-1:0] t);
      in_valid = 1'b1;
      op_a     = a;
      op_b     = b;
      copy_a   = ca;
      rmode    = rm;
      clip_ovr = cl;
      tag_in   = t;
   endtask

   task automatic expect_out(input string name, input logic [W-1:0] r, input logic [4:0] f,
                             input logic [TAGW-1:0] t);
      check_eq({name, "_vld"}, 64'(out_valid), 64'd1);
      check_eq({name, "_res"}, 64'(res), 64'(r));
      check_eq({name, "_flg"}, 64'(flags), 64'(f));
      check_eq({name, "_tag"}, 64'(tag_out), 64'(t));
   endtask

   // Offer one op into an empty pipe; result must appear on the third edge.
   task automatic run_single(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic ca, input logic [2:0] rm, input logic cl,
                             input logic [W-1:0] r, input logic [4:0] f);
      drive(a, b, ca, rm, cl, 6'h2A);
      @(posedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      check_eq({name, "_early"}, 64'(out_valid), 64'd0);
      @(posedge clk);
      expect_out(name, r, f, 6'h2A);
   endtask

   logic [W-1:0] sa[8], sb[8], sr[8];
   logic         sc[8];
   logic [2:0]   sm[8];
   logic [4:0]   sf[8];

   initial begin
      rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; copy_a = 1'b0;
      rmode = 3'd2; clip_ovr = 1'b0; tag_in = '0; flush = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      check_eq("rst_vld", 64'(out_valid), 64'd0);
      check_eq("rst_res", 64'(res), 64'd0);
      check_eq("rst_flg", 64'(flags), 64'd0);
      check_eq("rst_tag", 64'(tag_out), 64'd0);
      check_eq("rst_rdy", 64'(in_ready), 64'd1);
      rst = 1'b0;
      @(posedge clk);

      run_single("m1x2",     33'h0_7F80_0000, 33'h1_0000_0000, 0, 3'd2, 0, 33'h1_0000_0000, 5'b00000);
      run_single("m15x15",   33'h0_7FC0_0000, 33'h0_7FC0_0000, 0, 3'd2, 0, 33'h1_0010_0000, 5'b00000);
      run_single("neg",      33'h0_FFC0_0000, 33'h0_7FC0_0000, 0, 3'd2, 0, 33'h1_8010_0000, 5'b00000);
      run_single("r_trunc",  33'h0_7FC0_0001, 33'h0_7FC0_0000, 0, 3'd0, 0, 33'h1_0010_0000, 5'b10000);
      run_single("r_round",  33'h0_7FC0_0001, 33'h0_7FC0_0000, 0, 3'd1, 0, 33'h1_0010_0001, 5'b10000);
      run_single("r_up",     33'h0_7FC0_0001, 33'h0_7FC0_0000, 0, 3'd5, 0, 33'h1_0010_0001, 5'b10000);
      run_single("r_down",   33'h0_7FC0_0001, 33'h0_7FC0_0000, 0, 3'd6, 0, 33'h1_0010_0000, 5'b10000);
      run_single("r_downn",  33'h0_FFC0_0001, 33'h0_7FC0_0000, 0, 3'd6, 0, 33'h1_8010_0001, 5'b10000);
      run_single("tie_even", 33'h0_7FC0_0000, 33'h0_7FC0_0006, 0, 3'd2, 0, 33'h1_0010_0004, 5'b10000);
      run_single("tie_rnd",  33'h0_7FC0_0000, 33'h0_7FC0_0006, 0, 3'd1, 0, 33'h1_0010_0005, 5'b10000);
      run_single("tie_m7",   33'h0_7FC0_0000, 33'h0_7FC0_0006, 0, 3'd7, 0, 33'h1_0010_0004, 5'b10000);
      run_single("carry",    33'h0_7FFF_FFFE, 33'h0_7F80_0001, 0, 3'd1, 0, 33'h1_0000_0000, 5'b10000);
      run_single("nocarry",  33'h0_7FFF_FFFE, 33'h0_7F80_0001, 0, 3'd0, 0, 33'h0_7FFF_FFFF, 5'b10000);
      run_single("ovf",      33'h1_7800_0000, 33'h1_7800_0000, 0, 3'd2, 0, 33'h1_7F00_0000, 5'b10100);
      run_single("ovf_clip", 33'h1_7800_0000, 33'h1_7800_0000, 0, 3'd2, 1, 33'h1_7EFF_FFFF, 5'b10100);
      run_single("unf",      33'h0_8080_0000, 33'h0_0080_0000, 0, 3'd2, 0, 33'h0_8000_0000, 5'b01000);
      run_single("zxinf",    33'h0_0000_0000, 33'h1_7F00_0000, 0, 3'd2, 0, 33'h1_7FC0_0001, 5'b00011);
      run_single("infxm2",   33'h1_7F00_0000, 33'h1_8000_0000, 0, 3'd2, 0, 33'h1_FF00_0000, 5'b00001);
      run_single("nan",      33'h1_7F80_0000, 33'h0_7F80_0000, 0, 3'd2, 0, 33'h1_7FC0_0001, 5'b00011);
      run_single("nzero",    33'h0_8000_0000, 33'h1_0000_0000, 0, 3'd2, 0, 33'h0_8000_0000, 5'b00001);
      run_single("copya",    33'h1_7F80_0000, 33'h0_0000_0000, 1, 3'd2, 0, 33'h1_7F80_0000, 5'b00001);

      // back-to-back stream with per-op controls
      for (int i = 0; i < 8; i++) begin
         case (i % 4)
            0: begin sa[i] = 33'h0_7FC0_0000; sb[i] = 33'h0_7FC0_0000; sc[i] = 0; sm[i] = 3'd0;
                     sr[i] = 33'h1_0010_0000; sf[i] = 5'b00000; end
            1: begin sa[i] = 33'h0_1234_5678; sb[i] = 33'h0_7FC0_0000; sc[i] = 1; sm[i] = 3'd1;
                     sr[i] = 33'h0_1234_5678; sf[i] = 5'b00001; end
            2: begin sa[i] = 33'h0_7FC0_0000; sb[i] = 33'h0_7FC0_0006; sc[i] = 0; sm[i] = 3'd2;
                     sr[i] = 33'h1_0010_0004; sf[i] = 5'b10000; end
            default: begin sa[i] = 33'h0_7FC0_0000; sb[i] = 33'h0_7FC0_0006; sc[i] = 0; sm[i] = 3'd1;
                     sr[i] = 33'h1_0010_0005; sf[i] = 5'b10000; end
         endcase
      end
      for (int t = 0; t < 10; t++) begin
         if (t < 8) drive(sa[t], sb[t], sc[t], sm[t], 1'b0, TAGW'(t + 1));
         else in_valid = 1'b0;
         @(posedge clk);
         if (t >= 2) expect_out($sformatf("strm%0d", t - 1), sr[t-2], sf[t-2], TAGW'(t - 1));
      end
      @(posedge clk);
      check_eq("strm_end", 64'(out_valid), 64'd0);

      // stall with three in flight; a junk offer during the stall must be refused
      out_ready = 1'b0;
      drive(33'h0_7F80_0000, 33'h1_0000_0000, 0, 3'd2, 0, 6'd10);
      @(posedge clk);
      drive(33'h0_7FC0_0000, 33'h0_7FC0_0000, 0, 3'd2, 0, 6'd11);
      @(posedge clk);
      drive(33'h0_FFC0_0000, 33'h0_7FC0_0000, 0, 3'd2, 0, 6'd12);
      @(posedge clk);
      drive(33'h0_1111_1111, 33'h0_7F80_0000, 1, 3'd2, 0, 6'd63);
      for (int k = 0; k < 5; k++) begin
         check_eq($sformatf("stall%0d_rdy", k), 64'(in_ready), 64'd0);
         expect_out($sformatf("stall%0d", k), 33'h1_0000_0000, 5'b00000, 6'd10);
         @(posedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      expect_out("rel0", 33'h1_0000_0000, 5'b00000, 6'd10);
      @(posedge clk);
      expect_out("rel1", 33'h1_0010_0000, 5'b00000, 6'd11);
      @(posedge clk);
      expect_out("rel2", 33'h1_8010_0000, 5'b00000, 6'd12);
      @(posedge clk);
      check_eq("rel_end", 64'(out_valid), 64'd0);

      // flush while stalled
      out_ready = 1'b0;
      drive(33'h0_7F80_0000, 33'h1_0000_0000, 0, 3'd2, 0, 6'd20);
      @(posedge clk);
      drive(33'h0_7FC0_0000, 33'h0_7FC0_0000, 0, 3'd2, 0, 6'd21);
      @(posedge clk);
      drive(33'h0_7FC0_0000, 33'h0_7FC0_0000, 0, 3'd2, 0, 6'd22);
      @(posedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      expect_out("fl_pre", 33'h1_0000_0000, 5'b00000, 6'd20);
      flush = 1'b1;
      drive(33'h0_7F80_0000, 33'h0_7F80_0000, 0, 3'd2, 0, 6'd30);
      @(posedge clk);
      flush    = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      check_eq("fl_vld", 64'(out_valid), 64'd0);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         check_eq($sformatf("fl_post%0d", k), 64'(out_valid), 64'd0);
      end

      // async reset with three in flight
      drive(33'h0_7F80_0000, 33'h1_0000_0000, 0, 3'd2, 0, 6'd40);
      @(posedge clk);
      drive(33'h0_7F80_0000, 33'h1_0000_0000, 0, 3'd2, 0, 6'd41);
      @(posedge clk);
      drive(33'h0_7F80_0000, 33'h1_0000_0000, 0, 3'd2, 0, 6'd42);
      @(posedge clk);
      in_valid = 1'b0;
      expect_out("rs_pre", 33'h1_0000_0000, 5'b00000, 6'd40);
      #2 rst = 1'b1;
      #1;
      check_eq("rs_vld", 64'(out_valid), 64'd0);
      check_eq("rs_res", 64'(res), 64'd0);
      @(posedge clk);
      rst = 1'b0;
      check_eq("rs_rdy", 64'(in_ready), 64'd1);
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         check_eq($sformatf("rs_post%0d", k), 64'(out_valid), 64'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
